// File: rtl/voltmeter_level_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voltmeter_pkg
// Brief    : Shared types, default constants and parameter check for the
//            voltmeter level sampler.
// Revision : 1.0
// ============================================================================
package voltmeter_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int WINDOW_BITS_D = 10;
    localparam int TH1_D         = 256;
    localparam int TH2_D         = 512;
    localparam int TH3_D         = 768;
    localparam int HYST_D        = 16;

    // Legal settings keep the three level bits a thermometer code at all times.
    function automatic bit params_legal(input int wb, input int th1, input int th2,
                                        input int th3, input int hyst);
        return (wb >= 1) && (wb <= 30) &&
               (th1 < th2) && (th2 < th3) && (th3 <= (1 << wb)) &&
               (hyst >= 0) && (hyst < th1) &&
               (th2 - hyst >= th1) && (th3 - hyst >= th2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/voltmeter_level_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : voltmeter_level_sampler_if
// Brief    : Comparator/feedback loop and thermometer level outputs.
// Revision : 1.0
// ============================================================================
interface voltmeter_level_sampler_if;

    logic cmp_in;
    logic fb_out;
    logic BoogerA;
    logic BoogerB;
    logic BoogerC;
    logic sample_valid;

    modport master (
        output cmp_in,
        input  fb_out,
        input  BoogerA,
        input  BoogerB,
        input  BoogerC,
        input  sample_valid
    );

    modport slave (
        input  cmp_in,
        output fb_out,
        output BoogerA,
        output BoogerB,
        output BoogerC,
        output sample_valid
    );

endinterface
`default_nettype wire

// File: rtl/voltmeter_level_sampler_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchroniser with synchronous active-high reset.
// Revision : 1.0
// ============================================================================
module sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/voltmeter_level_sampler.sv
`default_nettype none
// ============================================================================
// Module   : voltmeter_level_sampler
// Brief    : Sigma-delta density counter producing a 3-bit thermometer level
//            with per-bit hysteresis, refreshed once per window.
// Revision : 1.0
// ============================================================================
module voltmeter_level_sampler
    import voltmeter_pkg::*;
#(
    parameter int WINDOW_BITS = WINDOW_BITS_D,
    parameter int TH1         = TH1_D,
    parameter int TH2         = TH2_D,
    parameter int TH3         = TH3_D,
    parameter int HYST        = HYST_D
) (
    input  wire logic                clk,
    input  wire logic                rst,
    voltmeter_level_sampler_if.slave bus
);

    localparam int CNT_W = WINDOW_BITS + 1;

    localparam logic [CNT_W-1:0] C_TH1_SET = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] C_TH2_SET = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] C_TH3_SET = CNT_W'(TH3);
    localparam logic [CNT_W-1:0] C_TH1_CLR = CNT_W'(TH1 - HYST);
    localparam logic [CNT_W-1:0] C_TH2_CLR = CNT_W'(TH2 - HYST);
    localparam logic [CNT_W-1:0] C_TH3_CLR = CNT_W'(TH3 - HYST);

    generate
        if (!params_legal(WINDOW_BITS, TH1, TH2, TH3, HYST)) begin : g_param_check
            $fatal(1, "voltmeter_level_sampler: illegal threshold/hysteresis parameters");
        end
    endgenerate

    logic                   w_cmp_s;
    logic                   r_fb;
    logic [WINDOW_BITS-1:0] r_win;
    logic [CNT_W-1:0]       r_ones;
    logic [CNT_W-1:0]       w_count_final;
    logic                   w_win_end;
    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_update;
    logic [2:0]             r_lvl;        // {C, B, A}
    logic [2:0]             w_lvl_next;
    logic                   r_valid;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (bus.cmp_in),
        .o_q (w_cmp_s)
    );

    // The window-end sample is folded in here so no ones are lost at the wrap.
    assign w_win_end     = &r_win;
    assign w_count_final = r_ones + CNT_W'(r_fb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb   <= 1'b0;
            r_win  <= '0;
            r_ones <= '0;
        end else begin
            r_fb   <= w_cmp_s;
            r_win  <= r_win + WINDOW_BITS'(1);
            r_ones <= w_win_end ? '0 : w_count_final;
        end
    end

    function automatic logic hyst_bit(input logic             cur,
                                      input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] th_set,
                                      input logic [CNT_W-1:0] th_clr);
        if (!cur) begin
            return (cnt >= th_set);
        end
        return !(cnt < th_clr);
    endfunction

    always_comb begin
        w_lvl_next    = r_lvl;
        w_lvl_next[0] = hyst_bit(r_lvl[0], w_count_final, C_TH1_SET, C_TH1_CLR);
        w_lvl_next[1] = hyst_bit(r_lvl[1], w_count_final, C_TH2_SET, C_TH2_CLR);
        w_lvl_next[2] = hyst_bit(r_lvl[2], w_count_final, C_TH3_SET, C_TH3_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first window after reset only primes the integrator loop.
    always_comb begin
        w_state_next = r_state;
        w_update     = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_win_end) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_win_end) begin
                    w_update = 1'b1;
                end
            end
            default: begin
                w_state_next = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl   <= 3'b000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_update;
            if (w_update) begin
                r_lvl <= w_lvl_next;
            end
        end
    end

    assign bus.fb_out       = r_fb;
    assign bus.BoogerA      = r_lvl[0];
    assign bus.BoogerB      = r_lvl[1];
    assign bus.BoogerC      = r_lvl[2];
    assign bus.sample_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_voltmeter_level_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_voltmeter_level_sampler
// Brief    : Self-checking bench: density tables, reset corners and random run.
// Revision : 1.0
// ============================================================================
module tb_voltmeter_level_sampler;

    localparam int WB   = 4;
    localparam int TH1  = 4;
    localparam int TH2  = 8;
    localparam int TH3  = 12;
    localparam int HYST = 2;
    localparam int WLEN = 1 << WB;
    localparam int NTBL = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    voltmeter_level_sampler_if bus ();

    voltmeter_level_sampler #(
        .WINDOW_BITS (WB),
        .TH1         (TH1),
        .TH2         (TH2),
        .TH3         (TH3),
        .HYST        (HYST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dens;   // ones per window fed back
        logic [2:0] exp;    // {C, B, A} after that window
    } vec_t;

    vec_t tbl [NTBL];

    int ncmp  = 0;
    int nfail = 0;

    // Reference model state, cycle index k counts from reset release.
    bit         hist[$];
    int         k;
    int         cnt;
    logic [2:0] m_lvl;
    logic       m_sv;
    int         last_pulse;
    int         first_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic logic [2:0] lvl_next(input logic [2:0] cur, input int count);
        int th [3];
        logic [2:0] nxt;
        th[0] = TH1; th[1] = TH2; th[2] = TH3;
        nxt = cur;
        for (int n = 0; n < 3; n++) begin
            if (!cur[n] && count >= th[n])             nxt[n] = 1'b1;
            else if (cur[n] && count < th[n] - HYST)   nxt[n] = 1'b0;
        end
        return nxt;
    endfunction

    function automatic logic [2:0] dut_lvl();
        return {bus.BoogerC, bus.BoogerB, bus.BoogerA};
    endfunction

    // Holds reset for n edges; returns at 1 time unit after an edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.cmp_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0; cnt = 0; m_lvl = 3'b000; m_sv = 1'b0;
        hist.delete();
        last_pulse = -1; first_pulse = -1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_fb"},     bus.fb_out,       0);
        chk({name, "_valid"},  bus.sample_valid, 0);
        chk({name, "_levels"}, dut_lvl(),        0);
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input bit c);
        logic exp_fb;
        logic [2:0] l;
        bus.cmp_in = c;
        hist.push_back(c);
        @(negedge clk);
        exp_fb = (k >= 3) ? hist[k-3] : 1'b0;
        l = dut_lvl();
        chk("fb_out",       bus.fb_out,       exp_fb);
        chk("sample_valid", bus.sample_valid, m_sv);
        chk("levels",       l,                m_lvl);
        chk("thermometer",  ((l[2] && !l[1]) || (l[1] && !l[0])) ? 1 : 0, 0);
        if (bus.sample_valid === 1'b1) begin
            if (first_pulse < 0) first_pulse = k;
            if (last_pulse >= 0) chk("valid_period", k - last_pulse, WLEN);
            last_pulse = k;
        end
        cnt += int'(exp_fb);
        m_sv = 1'b0;
        if (k % WLEN == WLEN - 1) begin
            if (k >= 2*WLEN - 1) begin
                chk("model_count_bound", (cnt <= WLEN) ? 1 : 0, 1);
                m_lvl = lvl_next(m_lvl, cnt);
                m_sv  = 1'b1;
            end
            cnt = 0;
        end
        k++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        bit c;
        int p;

        tbl[0]  = '{16, 3'b000};  // settle window, no update
        tbl[1]  = '{16, 3'b111};
        tbl[2]  = '{0,  3'b000};
        tbl[3]  = '{0,  3'b000};
        tbl[4]  = '{8,  3'b011};
        tbl[5]  = '{6,  3'b011};  // B holds at TH2-HYST
        tbl[6]  = '{5,  3'b001};
        tbl[7]  = '{0,  3'b000};
        tbl[8]  = '{4,  3'b001};  // exactly TH1 sets A
        tbl[9]  = '{3,  3'b001};
        tbl[10] = '{1,  3'b000};
        tbl[11] = '{16, 3'b111};

        bus.cmp_in = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);
        chk_zero("reset");

        // Density table; cmp drive is advanced 3 cycles to cover loop delay.
        while (k < WLEN*NTBL + 8) begin
            if (k >= 2*WLEN && k % WLEN == 0) begin
                chk("tbl_levels", dut_lvl(), tbl[k/WLEN - 1].exp);
                chk("tbl_pulse",  bus.sample_valid, 1);
            end
            if (k == WLEN) chk("settle_no_pulse", bus.sample_valid, 0);
            if (k == 2)    chk("fb_before_3", bus.fb_out, 0);
            if (k == 3)    chk("fb_at_3",     bus.fb_out, 1);
            idx = (k + 3) / WLEN;
            c = (idx < NTBL) ? (((k + 3) % WLEN) < tbl[idx].dens) : 1'b1;
            step(c);
        end

        // Mid-window reset while all levels are high.
        chk("pre_reset_levels", dut_lvl(), 3'b111);
        do_reset(1);
        chk_zero("mid_reset");
        for (int i = 0; i < 3*WLEN; i++) step(1'b1);
        chk("first_pulse_after_reset", first_pulse, 2*WLEN);

        // Reset coinciding with a RUN window end suppresses the pulse.
        do_reset(2);
        for (int i = 0; i < 2*WLEN - 1; i++) step(1'b1);
        do_reset(1);
        chk_zero("winend_reset");
        for (int i = 0; i < 4; i++) step(1'b0);

        // Random densities per window.
        do_reset(2);
        for (int w = 0; w < 600; w++) begin
            p = $urandom_range(0, WLEN);
            for (int j = 0; j < WLEN; j++) step($urandom_range(0, WLEN - 1) < p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
